// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-wide RAM slave with UART TX FIFO and halt register
// Registered 1-cycle reads; I/O window at a_in[17:16]==2'b11.
module mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] a_in,
  input  logic [7:0]  d_in,
  input  logic        wr_in,
  output logic [7:0]  d_out,
  output logic        io_buffer_full,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  output logic        halt_out,
  output logic [7:0]  drop_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_MARK = CW'(FIFO_DEPTH - 1);
  localparam logic [17:0]   UART_ADDR = 18'h30000;
  localparam logic [17:0]   HALT_ADDR = 18'h30004;

  logic [7:0] ram [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] fifo [0:FIFO_DEPTH-1];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  logic [ADDR_WIDTH-1:0] idx;
  logic is_io, ram_wr, ram_rd, push_req, push, pop, drop, halt_wr;
  logic unused_hi;

  assign unused_hi     = ^a_in[31:18];
  assign uart_tx_valid = rdy && (count != '0);
  assign uart_tx_data  = fifo[rd_ptr];

  always_comb begin
    idx      = a_in[ADDR_WIDTH-1:0];
    is_io    = (a_in[17:16] == 2'b11);
    ram_wr   = rdy && wr_in && !is_io;
    ram_rd   = !wr_in && !is_io;
    push_req = rdy && wr_in && (a_in[17:0] == UART_ADDR);
    halt_wr  = rdy && wr_in && (a_in[17:0] == HALT_ADDR);
    pop      = uart_tx_valid && uart_tx_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push     = push_req && ((count < DEPTH) || pop);
    drop     = push_req && !push;
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (ram_wr)
      ram[idx] <= d_in;
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo[wr_ptr] <= d_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out          <= 8'h00;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      io_buffer_full <= 1'b0;
      drop_count     <= 8'h00;
      halt_out       <= 1'b0;
    end else if (rdy) begin
      d_out <= ram_rd ? ram[idx] : 8'h00;
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count          <= count_next;
      io_buffer_full <= (count_next >= FULL_MARK);
      if (drop && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
      if (halt_wr)
        halt_out <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - table-driven plus randomized check of mem_responder
// Reference model: associative RAM, byte queue FIFO, plain flags.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst, rdy, wr_in, uart_tx_ready;
  logic [31:0] a_in;
  logic [7:0]  d_in;
  logic [7:0]  d_out, uart_tx_data, drop_count;
  logic        io_buffer_full, uart_tx_valid, halt_out;

  mem_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .a_in(a_in), .d_in(d_in), .wr_in(wr_in),
    .d_out(d_out), .io_buffer_full(io_buffer_full), .uart_tx_valid(uart_tx_valid),
    .uart_tx_data(uart_tx_data), .uart_tx_ready(uart_tx_ready),
    .halt_out(halt_out), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] ram_m [int];
  logic [7:0] fifo_m [$];
  logic       halt_m, full_m, dout_known;
  logic [7:0] drop_m, dout_m;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic [7:0]  dout;
    logic        full;
    logic        valid;
    logic        halt;
    logic [7:0]  drop;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    fifo_m.delete();
    halt_m = 1'b0; full_m = 1'b0; drop_m = 8'd0;
    dout_m = 8'd0; dout_known = 1'b1;
  endtask

  task automatic model_edge();
    logic io, pop, push_req, accept;
    int   idx;
    if (!rdy) return;
    io       = (a_in[17:16] == 2'b11);
    idx      = int'(a_in[16:0]);
    pop      = (fifo_m.size() != 0) && uart_tx_ready;
    push_req = wr_in && (a_in[17:0] == 18'h30000);
    accept   = push_req && (fifo_m.size() < 8 || pop);
    if (pop) void'(fifo_m.pop_front());
    if (accept) fifo_m.push_back(d_in);
    if (push_req && !accept && drop_m != 8'd255) drop_m = drop_m + 8'd1;
    if (wr_in && a_in[17:0] == 18'h30004) halt_m = 1'b1;
    full_m = (fifo_m.size() >= 7);
    if (!io && !wr_in) begin
      dout_known = ram_m.exists(idx);
      dout_m     = dout_known ? ram_m[idx] : 8'h00;
    end else begin
      dout_known = 1'b1;
      dout_m     = 8'h00;
    end
    if (!io && wr_in) ram_m[idx] = d_in;
  endtask

  task automatic check_all();
    if (dout_known) chk("d_out", d_out, dout_m);
    chk("io_buffer_full", io_buffer_full, full_m);
    chk("uart_tx_valid", uart_tx_valid, rdy && fifo_m.size() != 0);
    if (rdy && fifo_m.size() != 0) chk("uart_tx_data", uart_tx_data, fifo_m[0]);
    chk("halt_out", halt_out, halt_m);
    chk("drop_count", drop_count, drop_m);
  endtask

  // Called at a falling edge: drive, advance the model, check at the next falling edge.
  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [7:0] d, input logic rd);
    rdy = r; wr_in = w; a_in = a; d_in = d; uart_tx_ready = rd;
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic add(input logic w, input logic [31:0] a, input logic [7:0] d,
                     input logic [7:0] dout, input logic full, input logic valid,
                     input logic halt, input logic [7:0] drop);
    vec_t v;
    v.wr = w; v.a = a; v.d = d; v.dout = dout; v.full = full;
    v.valid = valid; v.halt = halt; v.drop = drop;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] drained [$];
    logic [7:0] pre [4];
    logic [31:0] r;
    pre[0] = 8'h13; pre[1] = 8'h05; pre[2] = 8'h00; pre[3] = 8'h00;

    add(1, 32'h00010, 8'hA5, 8'h00, 0, 0, 0, 0);
    add(0, 32'h00010, 8'h00, 8'hA5, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 32'h100 + i, pre[i], 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 32'h100 + i, 8'h00, pre[i], 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) add(1, 32'h30000, 8'h40 + k[7:0], 8'h00, k == 6, 1, 0, 0);
    add(1, 32'h30000, 8'h47, 8'h00, 1, 1, 0, 0);
    add(1, 32'h30000, 8'h48, 8'h00, 1, 1, 0, 1);
    add(0, 32'h30000, 8'h00, 8'h00, 1, 1, 0, 1);
    add(1, 32'h30008, 8'h99, 8'h00, 1, 1, 0, 1);
    add(1, 32'h30004, 8'h00, 8'h00, 1, 1, 1, 1);
    add(0, 32'hFFFC0010, 8'h00, 8'hA5, 1, 1, 1, 1);

    rst = 1'b1; rdy = 1'b1; wr_in = 1'b0; a_in = '0; d_in = '0; uart_tx_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(1'b1, tbl[i].wr, tbl[i].a, tbl[i].d, 1'b0);
      chk($sformatf("tbl%0d.d_out", i), d_out, tbl[i].dout);
      chk($sformatf("tbl%0d.full", i), io_buffer_full, tbl[i].full);
      chk($sformatf("tbl%0d.valid", i), uart_tx_valid, tbl[i].valid);
      chk($sformatf("tbl%0d.halt", i), halt_out, tbl[i].halt);
      chk($sformatf("tbl%0d.drop", i), drop_count, tbl[i].drop);
    end

    // Full FIFO: push and pop together, then drain in order.
    step(1'b1, 1'b1, 32'h30000, 8'h50, 1'b1);
    chk("pushpop_full", io_buffer_full, 1'b1);
    chk("pushpop_drop", drop_count, 8'd1);
    for (int n = 0; n < 12 && uart_tx_valid; n++) begin
      drained.push_back(uart_tx_data);
      step(1'b1, 1'b0, 32'h00010, 8'h00, 1'b1);
    end
    chk("drain_len", drained.size(), 8);
    for (int i = 0; i < 8 && i < drained.size(); i++)
      chk($sformatf("drain%0d", i), drained[i], (i < 7) ? 8'h41 + i[7:0] : 8'h50);
    chk("drain_full_clear", io_buffer_full, 1'b0);

    // rdy low freezes everything.
    step(1'b1, 1'b1, 32'h30000, 8'h61, 1'b0);
    step(1'b1, 1'b0, 32'h00100, 8'h00, 1'b0);
    step(1'b0, 1'b1, 32'h00010, 8'hFF, 1'b1);
    step(1'b0, 1'b1, 32'h30000, 8'h62, 1'b1);
    step(1'b0, 1'b0, 32'h00101, 8'h00, 1'b1);
    chk("rdy0_valid", uart_tx_valid, 1'b0);
    chk("rdy0_dout_hold", d_out, 8'h13);
    step(1'b1, 1'b0, 32'h00010, 8'h00, 1'b0);
    chk("rdy0_no_ram_wr", d_out, 8'hA5);
    chk("rdy0_fifo_head", uart_tx_data, 8'h61);
    step(1'b1, 1'b0, 32'h00010, 8'h00, 1'b1);
    chk("rdy0_no_push", uart_tx_valid, 1'b0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int sel;
      r   = $urandom();
      sel = $urandom_range(0, 9);
      case (sel)
        0:       a = 32'h10;
        1, 2, 3, 4: a = 32'h100 + sel - 1;
        5, 6:    a = 32'h30000;
        7:       a = 32'h30004;
        8:       a = 32'h30008;
        default: a = 32'h20 + $urandom_range(0, 15);
      endcase
      a[31:18] = r[13:0];
      step($urandom_range(0, 7) != 0, r[14], a, r[23:16], r[15]);
    end

    // Drop counter saturation.
    for (int n = 0; n < 270; n++) step(1'b1, 1'b1, 32'h30000, n[7:0], 1'b0);
    chk("drop_saturate", drop_count, 8'd255);

    // Asynchronous reset mid-cycle.
    #2 rst = 1'b1;
    #1;
    chk("rst_d_out", d_out, 8'h00);
    chk("rst_full", io_buffer_full, 1'b0);
    chk("rst_valid", uart_tx_valid, 1'b0);
    chk("rst_halt", halt_out, 1'b0);
    chk("rst_drop", drop_count, 8'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 32'h00010, 8'h00, 1'b1);
    chk("post_rst_empty", uart_tx_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Byte-wide memory responder at the far end of the core's memory bus: the slave side of the address/data/write-strobe interface driven by the instruction/data cache. It holds the RAM array, returns read data one cycle after the address is presented, and decodes a small I/O window. That window feeds a UART transmit FIFO, drives the `io_buffer_full` back-pressure flag and provides a sticky halt register.

## Interface
- `ADDR_WIDTH`, default 17: RAM is 2^ADDR_WIDTH bytes, indexed by `a_in[ADDR_WIDTH-1:0]`.
- `FIFO_DEPTH`, default 8: UART TX FIFO entries (power of two, ≥4).
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `rdy` in 1: global enable; low freezes all state.
- `a_in` in 32: byte address from the initiator; only bits 17:0 are decoded.
- `d_in` in 8: write data from the initiator.
- `wr_in` in 1: 1 = write this cycle, 0 = read.
- `d_out` out 8: registered read data to the initiator.
- `io_buffer_full` out 1: UART FIFO back-pressure flag to the initiator.
- `uart_tx_valid` out 1: FIFO head byte available.
- `uart_tx_data` out 8: FIFO head byte.
- `uart_tx_ready` in 1: sink accepts the head byte this cycle.
- `halt_out` out 1: sticky program-end flag.
- `drop_count` out 8: saturating count of UART bytes dropped on overflow.

## Operation
- Decode: I/O when `a_in[17:16]==2'b11`; otherwise RAM at `a_in[ADDR_WIDTH-1:0]`. Bits 31:18 are ignored.
- RAM read (`wr_in=0`, RAM region): `d_out <= ram[idx]` at the edge.
- RAM write (`wr_in=1`, RAM region): `ram[idx] <= d_in` at the edge, and `d_out <= 8'h00`.
- I/O read: `d_out <= 8'h00` at every I/O address.
- I/O write to `0x30000`: push `d_in` into the FIFO.
- I/O write to `0x30004`: set `halt_out` (sticky).
- I/O write to any other I/O address: ignored, and `d_out <= 8'h00`.
- FIFO accepts a push when `count < FIFO_DEPTH` or when a pop occurs in the same cycle.
  - A push that is not accepted drops the byte and increments `drop_count`, saturating at 255.
  - `count` is held at `$clog2(FIFO_DEPTH)+1` bits.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- Pop occurs when `uart_tx_valid && uart_tx_ready`.
- Simultaneous push and pop: both take effect, `count` unchanged. Order is preserved, including when `count==0`: the new byte is not visible at the head until the next cycle.
- `uart_tx_valid = rdy && (count != 0)`. `uart_tx_data` is the head entry, combinational from the FIFO array.
- `io_buffer_full = (count >= FIFO_DEPTH-1)`, registered from the post-update count. The one-slot slack absorbs the initiator's one-cycle reaction lag.
- `rdy` low: no RAM write, no push, no pop, `d_out` and all counters hold.
- `halt_out` has no effect on bus service; writes and reads continue to be honoured.
- Reset values:
  - `d_out` = 0, `io_buffer_full` = 0, `halt_out` = 0, `drop_count` = 0.
  - FIFO empty, pointers = 0, so `uart_tx_valid` = 0.
  - RAM contents are not reset.
- Reset asserted mid-transfer: FIFO contents are discarded and any in-flight read result is lost (`d_out` = 0). The initiator is reset by the same signal.

## Timing
- Read latency is exactly 1 cycle: address in cycle N gives data on `d_out` in cycle N+1. A new address may be presented every cycle, so back-to-back byte reads stream one byte per cycle.
- Write is committed at the edge ending the cycle in which `wr_in=1`. A read of the same address in the next cycle returns the new value.
- `io_buffer_full` changes one cycle after the push/pop that crosses the `FIFO_DEPTH-1` threshold.
- `drop_count` and `halt_out` update one cycle after the offending write.
- No combinational path from `a_in`/`d_in`/`wr_in` to any output.

## Test plan
- Write 0xA5 to 0x00010, then read 0x00010 in the next cycle → `d_out==8'hA5` one cycle after the read address.
- Stream reads of 0x100–0x103 preloaded with 0x13,0x05,0x00,0x00 → `d_out` yields those bytes on consecutive cycles, each 1 cycle late.
- With `uart_tx_ready=0`, write 7 bytes to 0x30000 → `io_buffer_full` high the cycle after the 7th write. Write 2 more → 8th accepted, 9th dropped, `drop_count==1`.
- With the FIFO full, raise `uart_tx_ready` and push in the same cycle → push accepted, count stays 8, bytes drain in exact write order.
- Write 0x30004 → `halt_out==1` next cycle and it stays high. Assert `rst` → all outputs 0 immediately (asynchronous) and the FIFO is empty.
- Hold `rdy=0` while driving writes and reads → RAM, FIFO, `d_out` and counters unchanged, `uart_tx_valid==0`.
